// File: rtl/eth_recv_dns_if.sv
// Receive-side AXI-Stream beat bundle from the 10G MAC; no backpressure.
interface eth_recv_dns_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/eth_recv_dns.sv
// Ethernet/IPv4/UDP/DNS header parser for the 64-bit MAC RX stream.
// Flags DNS responses addressed to this node and keeps frame/match/drop counters.
module eth_recv_dns #(
  parameter logic [47:0] MAC_ADDR   = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [31:0] IP_ADDR    = {8'd10, 8'd0, 8'd0, 8'd1},
  parameter logic [15:0] DNS_PORT   = 16'd53,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input  logic          clk156,
  input  logic          sys_rst_n,
  eth_recv_dns_if.slave m_axis_rx,
  output logic          res_valid,
  output logic [31:0]   res_saddr,
  output logic [15:0]   res_dport,
  output logic [15:0]   res_dns_id,
  output logic [31:0]   rx_pkt_cnt,
  output logic [31:0]   rx_dns_cnt,
  output logic [31:0]   rx_drop_cnt
);
  localparam int unsigned ACC_W     = 20;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned BEAT_W    = 3;
  localparam logic [BEAT_W-1:0] LAST_HDR_BEAT = BEAT_W'(5);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [47:0]        h_dest_q, h_dest_d;
  logic [15:0]        h_proto_q, h_proto_d;
  logic [7:0]         ver_ihl_q, ver_ihl_d;
  logic [7:0]         ip_proto_q, ip_proto_d;
  logic [31:0]        saddr_q, saddr_d;
  logic [31:0]        daddr_q, daddr_d;
  logic [15:0]        sport_q, sport_d;
  logic [15:0]        dport_q, dport_d;
  logic [15:0]        dns_id_q, dns_id_d;
  logic               qr_q, qr_d;
  logic               keep_bad_q, keep_bad_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_saddr_q, res_saddr_d;
  logic [15:0]        res_dport_q, res_dport_d;
  logic [15:0]        res_dns_id_q, res_dns_id_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   dns_cnt_q, dns_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [7:0]         lane [8];
  logic [15:0]        word [4];
  logic [16:0]        fold1_c;
  logic [15:0]        fold2_c;
  logic               runt_c, err_c, match_c;
  logic               unused_keep_c;

  assign unused_keep_c = ^m_axis_rx.tkeep[7:6];

  // Byte lanes and big-endian 16-bit words of the current beat
  always_comb begin
    for (int k = 0; k < 8; k++) lane[k] = m_axis_rx.tdata[8*k +: 8];
    for (int k = 0; k < 4; k++) word[k] = {lane[2*k], lane[2*k+1]};
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    h_dest_d     = h_dest_q;
    h_proto_d    = h_proto_q;
    ver_ihl_d    = ver_ihl_q;
    ip_proto_d   = ip_proto_q;
    saddr_d      = saddr_q;
    daddr_d      = daddr_q;
    sport_d      = sport_q;
    dport_d      = dport_q;
    dns_id_d     = dns_id_q;
    qr_d         = qr_q;
    keep_bad_d   = keep_bad_q;
    acc_d        = acc_q;
    res_valid_d  = 1'b0;
    res_saddr_d  = res_saddr_q;
    res_dport_d  = res_dport_q;
    res_dns_id_d = res_dns_id_q;
    pkt_cnt_d    = pkt_cnt_q;
    dns_cnt_d    = dns_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    // Header capture; beat_q is 0 while idle so it indexes the header beat directly
    if (m_axis_rx.tvalid && state_q != ST_PAYLOAD) begin
      case (beat_q)
        BEAT_W'(0): begin
          h_dest_d   = {lane[0], lane[1], lane[2], lane[3], lane[4], lane[5]};
          acc_d      = '0;
          keep_bad_d = 1'b0;
        end
        BEAT_W'(1): begin
          h_proto_d = {lane[4], lane[5]};
          ver_ihl_d = lane[6];
          acc_d     = acc_q + ACC_W'(word[3]);
        end
        BEAT_W'(2): begin
          ip_proto_d = lane[7];
          acc_d      = acc_q + ACC_W'(word[0]) + ACC_W'(word[1])
                             + ACC_W'(word[2]) + ACC_W'(word[3]);
        end
        BEAT_W'(3): begin
          saddr_d        = {lane[2], lane[3], lane[4], lane[5]};
          daddr_d[31:16] = {lane[6], lane[7]};
          acc_d          = acc_q + ACC_W'(word[0]) + ACC_W'(word[1])
                                 + ACC_W'(word[2]) + ACC_W'(word[3]);
        end
        BEAT_W'(4): begin
          daddr_d[15:0] = {lane[0], lane[1]};
          sport_d       = {lane[2], lane[3]};
          dport_d       = {lane[4], lane[5]};
          acc_d         = acc_q + ACC_W'(word[0]);
        end
        BEAT_W'(5): begin
          dns_id_d   = {lane[2], lane[3]};
          qr_d       = lane[4][7];
          keep_bad_d = (m_axis_rx.tkeep[5:0] != 6'h3F);
        end
        default: ;
      endcase
    end

    fold1_c = 17'(acc_d[15:0]) + 17'(acc_d[ACC_W-1:16]);
    fold2_c = fold1_c[15:0] + 16'(fold1_c[16]);
    runt_c  = ((state_q != ST_PAYLOAD) && (beat_q < LAST_HDR_BEAT)) || keep_bad_d;
    err_c   = m_axis_rx.tuser || runt_c || (CHECK_CSUM && (fold2_c != 16'hFFFF));
    match_c = !err_c && (h_dest_d == MAC_ADDR) && (h_proto_d == 16'h0800)
              && (ver_ihl_d == 8'h45) && (ip_proto_d == 8'd17)
              && (daddr_d == IP_ADDR) && (sport_d == DNS_PORT) && qr_d;

    if (m_axis_rx.tvalid) begin
      if (m_axis_rx.tlast) begin
        state_d   = ST_IDLE;
        beat_d    = '0;
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        if (err_c) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        if (match_c) begin
          dns_cnt_d    = dns_cnt_q + CNT_W'(1);
          res_valid_d  = 1'b1;
          res_saddr_d  = saddr_d;
          res_dport_d  = dport_d;
          res_dns_id_d = dns_id_d;
        end
      end else if (state_q == ST_IDLE) begin
        state_d = ST_HDR;
        beat_d  = BEAT_W'(1);
      end else if (state_q == ST_HDR) begin
        if (beat_q == LAST_HDR_BEAT) state_d = ST_PAYLOAD;
        else                         beat_d  = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      h_dest_q     <= '0;
      h_proto_q    <= '0;
      ver_ihl_q    <= '0;
      ip_proto_q   <= '0;
      saddr_q      <= '0;
      daddr_q      <= '0;
      sport_q      <= '0;
      dport_q      <= '0;
      dns_id_q     <= '0;
      qr_q         <= 1'b0;
      keep_bad_q   <= 1'b0;
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_saddr_q  <= '0;
      res_dport_q  <= '0;
      res_dns_id_q <= '0;
      pkt_cnt_q    <= '0;
      dns_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      h_dest_q     <= h_dest_d;
      h_proto_q    <= h_proto_d;
      ver_ihl_q    <= ver_ihl_d;
      ip_proto_q   <= ip_proto_d;
      saddr_q      <= saddr_d;
      daddr_q      <= daddr_d;
      sport_q      <= sport_d;
      dport_q      <= dport_d;
      dns_id_q     <= dns_id_d;
      qr_q         <= qr_d;
      keep_bad_q   <= keep_bad_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_saddr_q  <= res_saddr_d;
      res_dport_q  <= res_dport_d;
      res_dns_id_q <= res_dns_id_d;
      pkt_cnt_q    <= pkt_cnt_d;
      dns_cnt_q    <= dns_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_saddr   = res_saddr_q;
  assign res_dport   = res_dport_q;
  assign res_dns_id  = res_dns_id_q;
  assign rx_pkt_cnt  = pkt_cnt_q;
  assign rx_dns_cnt  = dns_cnt_q;
  assign rx_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_eth_recv_dns.sv
// Directed bench for eth_recv_dns: table of single-frame vectors, a gapped
// back-to-back burst and a mid-frame reset, against checksum-on and -off instances.
module tb_eth_recv_dns;
  localparam logic [47:0] MAC = 48'h90E2BA5D8DC8;
  localparam logic [31:0] IP  = 32'h0A000001;

  typedef struct {
    string       name;
    logic [47:0] mac;
    logic [31:0] saddr;
    logic [31:0] daddr;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] id;
    logic        qr;
    logic [7:0]  verihl;
    logic        bad_csum;
    int          nbeats;
    logic [7:0]  last_keep;
    logic        tuser;
    logic        m_chk;    // expected match, checksum enforced
    logic        m_nochk;  // expected match, checksum ignored
    logic        d_chk;    // expected drop, checksum enforced
    logic        d_nochk;  // expected drop, checksum ignored
  } vec_t;

  logic clk156 = 1'b0;
  logic sys_rst_n;
  always #5 clk156 = ~clk156;

  eth_recv_dns_if rx_if();

  logic        a_valid, b_valid;
  logic [31:0] a_saddr, b_saddr, a_pkt, b_pkt, a_dns, b_dns, a_drop, b_drop;
  logic [15:0] a_dport, b_dport, a_id, b_id;

  eth_recv_dns u_chk (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .m_axis_rx(rx_if),
    .res_valid(a_valid), .res_saddr(a_saddr), .res_dport(a_dport), .res_dns_id(a_id),
    .rx_pkt_cnt(a_pkt), .rx_dns_cnt(a_dns), .rx_drop_cnt(a_drop));

  eth_recv_dns #(.CHECK_CSUM(1'b0)) u_nochk (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .m_axis_rx(rx_if),
    .res_valid(b_valid), .res_saddr(b_saddr), .res_dport(b_dport), .res_dns_id(b_id),
    .rx_pkt_cnt(b_pkt), .rx_dns_cnt(b_dns), .rx_drop_cnt(b_drop));

  int checks = 0;
  int failures = 0;
  int pulses_a = 0, pulses_b = 0, width_err = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] fb [0:1023];

  // Pulse counting and one-cycle-width monitor
  always @(negedge clk156) begin
    if (a_valid) pulses_a <= pulses_a + 1;
    if (b_valid) pulses_b <= pulses_b + 1;
    if ((a_valid && prev_a) || (b_valid && prev_b)) width_err <= width_err + 1;
    prev_a <= a_valid;
    prev_b <= b_valid;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ip_csum();
    logic [31:0] s;
    s = '0;
    for (int i = 14; i < 34; i += 2) s = s + {16'h0, fb[i], fb[i+1]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build(input vec_t v);
    logic [15:0] cs;
    for (int i = 0; i < 1024; i++) fb[i] = 8'(i * 7 + 3);
    for (int k = 0; k < 6; k++) fb[k] = v.mac[47-8*k -: 8];
    fb[6] = 8'h02; fb[7] = 8'h00; fb[8] = 8'h00; fb[9] = 8'h00; fb[10] = 8'h00; fb[11] = 8'h01;
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = v.verihl; fb[15] = 8'h00;
    fb[16] = 8'h00; fb[17] = 8'h40; fb[18] = 8'h12; fb[19] = 8'h34;
    fb[20] = 8'h40; fb[21] = 8'h00; fb[22] = 8'd64; fb[23] = 8'd17;
    fb[24] = 8'h00; fb[25] = 8'h00;
    for (int k = 0; k < 4; k++) fb[26+k] = v.saddr[31-8*k -: 8];
    for (int k = 0; k < 4; k++) fb[30+k] = v.daddr[31-8*k -: 8];
    fb[34] = v.sport[15:8]; fb[35] = v.sport[7:0];
    fb[36] = v.dport[15:8]; fb[37] = v.dport[7:0];
    fb[38] = 8'h00; fb[39] = 8'h2C; fb[40] = 8'h00; fb[41] = 8'h00;
    fb[42] = v.id[15:8]; fb[43] = v.id[7:0];
    fb[44] = v.qr ? 8'h81 : 8'h01; fb[45] = 8'h80;
    cs = ip_csum();
    fb[24] = cs[15:8];
    fb[25] = v.bad_csum ? (cs[7:0] ^ 8'h01) : cs[7:0];
  endtask

  // Gap cycles carry junk with tlast/tuser high to prove tvalid gating
  task automatic send_beats(input int first, input int last, input bit with_last,
                            input logic [7:0] last_keep, input bit tuser, input int gap_max);
    for (int b = first; b <= last; b++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
      repeat (gaps) begin
        @(negedge clk156);
        rx_if.tvalid = 1'b0; rx_if.tdata = {$urandom, $urandom};
        rx_if.tkeep = 8'h00; rx_if.tlast = 1'b1; rx_if.tuser = 1'b1;
      end
      @(negedge clk156);
      rx_if.tvalid = 1'b1;
      for (int k = 0; k < 8; k++) rx_if.tdata[8*k +: 8] = fb[8*b + k];
      rx_if.tlast = with_last && (b == last);
      rx_if.tkeep = rx_if.tlast ? last_keep : 8'hFF;
      rx_if.tuser = rx_if.tlast && tuser;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk156);
      rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".res_valid"}, 64'(a_valid), 64'd0);
    chk({tag, ".res_saddr"}, 64'(a_saddr), 64'd0);
    chk({tag, ".res_dport"}, 64'(a_dport), 64'd0);
    chk({tag, ".res_dns_id"}, 64'(a_id), 64'd0);
    chk({tag, ".pkt_cnt"}, 64'(a_pkt), 64'd0);
    chk({tag, ".dns_cnt"}, 64'(a_dns), 64'd0);
    chk({tag, ".drop_cnt"}, 64'(a_drop), 64'd0);
  endtask

  vec_t base, v;
  vec_t vecs[$];
  logic [31:0] ea_saddr, eb_saddr;
  logic [15:0] ea_dport, eb_dport, ea_id, eb_id;
  logic [31:0] pa, pb, da, db, ra, rb;
  int qa, qb;

  task automatic snap();
    pa = a_pkt; pb = b_pkt; da = a_dns; db = b_dns; ra = a_drop; rb = b_drop;
    qa = pulses_a; qb = pulses_b;
  endtask

  initial begin
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tkeep = '0;
    rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk156);
    chk_zero("reset");
    sys_rst_n = 1'b1;
    idle(2);

    base = '{name: "good127", mac: MAC, saddr: 32'h0A01_0101, daddr: IP, sport: 16'd53,
             dport: 16'd50001, id: 16'h1234, qr: 1'b1, verihl: 8'h45, bad_csum: 1'b0,
             nbeats: 127, last_keep: 8'hFF, tuser: 1'b0,
             m_chk: 1'b1, m_nochk: 1'b1, d_chk: 1'b0, d_nochk: 1'b0};
    v = base; vecs.push_back(v);
    v = base; v.name = "bad_csum";   v.bad_csum = 1'b1; v.m_chk = 1'b0; v.d_chk = 1'b1; vecs.push_back(v);
    v = base; v.name = "wrong_mac";  v.mac = MAC ^ 48'h1; v.m_chk = 1'b0; v.m_nochk = 1'b0; vecs.push_back(v);
    v = base; v.name = "qr0";        v.qr = 1'b0; v.m_chk = 1'b0; v.m_nochk = 1'b0; vecs.push_back(v);
    v = base; v.name = "sport54";    v.sport = 16'd54; v.m_chk = 1'b0; v.m_nochk = 1'b0; vecs.push_back(v);
    v = base; v.name = "tlast_b3";   v.nbeats = 4; v.m_chk = 1'b0; v.m_nochk = 1'b0;
              v.d_chk = 1'b1; v.d_nochk = 1'b1; vecs.push_back(v);
    v = base; v.name = "tuser";      v.nbeats = 20; v.tuser = 1'b1; v.m_chk = 1'b0; v.m_nochk = 1'b0;
              v.d_chk = 1'b1; v.d_nochk = 1'b1; vecs.push_back(v);
    v = base; v.name = "one_beat";   v.nbeats = 1; v.m_chk = 1'b0; v.m_nochk = 1'b0;
              v.d_chk = 1'b1; v.d_nochk = 1'b1; vecs.push_back(v);
    v = base; v.name = "b5_keep3f";  v.nbeats = 6; v.last_keep = 8'h3F; vecs.push_back(v);
    v = base; v.name = "b5_keep1f";  v.nbeats = 6; v.last_keep = 8'h1F; v.m_chk = 1'b0; v.m_nochk = 1'b0;
              v.d_chk = 1'b1; v.d_nochk = 1'b1; vecs.push_back(v);
    v = base; v.name = "wrong_ip";   v.daddr = 32'h0A00_0002; v.m_chk = 1'b0; v.m_nochk = 1'b0; vecs.push_back(v);
    v = base; v.name = "ihl46";      v.verihl = 8'h46; v.m_chk = 1'b0; v.m_nochk = 1'b0; vecs.push_back(v);
    v = base; v.name = "b6_keep01";  v.nbeats = 7; v.last_keep = 8'h01; v.saddr = 32'hC0A8_0102; vecs.push_back(v);

    ea_saddr = '0; eb_saddr = '0; ea_dport = '0; eb_dport = '0; ea_id = '0; eb_id = '0;
    foreach (vecs[i]) begin
      v = vecs[i];
      if (i > 0) begin
        v.dport = 16'(50001 + i);
        v.id    = 16'(16'h1234 + i);
      end
      snap();
      build(v);
      send_beats(0, v.nbeats - 1, 1'b1, v.last_keep, v.tuser, 0);
      idle(3);
      if (v.m_chk)   begin ea_saddr = v.saddr; ea_dport = v.dport; ea_id = v.id; end
      if (v.m_nochk) begin eb_saddr = v.saddr; eb_dport = v.dport; eb_id = v.id; end
      chk({v.name, ".pkt_a"},   64'(32'(a_pkt - pa)),  64'd1);
      chk({v.name, ".pkt_b"},   64'(32'(b_pkt - pb)),  64'd1);
      chk({v.name, ".dns_a"},   64'(32'(a_dns - da)),  64'(v.m_chk));
      chk({v.name, ".dns_b"},   64'(32'(b_dns - db)),  64'(v.m_nochk));
      chk({v.name, ".drop_a"},  64'(32'(a_drop - ra)), 64'(v.d_chk));
      chk({v.name, ".drop_b"},  64'(32'(b_drop - rb)), 64'(v.d_nochk));
      chk({v.name, ".pulse_a"}, 64'(pulses_a - qa),    64'(v.m_chk));
      chk({v.name, ".pulse_b"}, 64'(pulses_b - qb),    64'(v.m_nochk));
      chk({v.name, ".saddr_a"}, 64'(a_saddr), 64'(ea_saddr));
      chk({v.name, ".dport_a"}, 64'(a_dport), 64'(ea_dport));
      chk({v.name, ".id_a"},    64'(a_id),    64'(ea_id));
      chk({v.name, ".saddr_b"}, 64'(b_saddr), 64'(eb_saddr));
      chk({v.name, ".dport_b"}, 64'(b_dport), 64'(eb_dport));
      chk({v.name, ".id_b"},    64'(b_id),    64'(eb_id));
    end

    // 1000 matching 8-beat frames, random gaps, zero-gap back-to-back allowed
    snap();
    for (int i = 0; i < 1000; i++) begin
      v = base; v.nbeats = 8; v.dport = 16'(50001 + i); v.id = 16'(i + 1);
      build(v);
      send_beats(0, 7, 1'b1, 8'hFF, 1'b0, 1);
    end
    idle(3);
    chk("burst.pkt_a",   64'(32'(a_pkt - pa)),  64'd1000);
    chk("burst.dns_a",   64'(32'(a_dns - da)),  64'd1000);
    chk("burst.dns_b",   64'(32'(b_dns - db)),  64'd1000);
    chk("burst.drop_a",  64'(32'(a_drop - ra)), 64'd0);
    chk("burst.pulse_a", 64'(pulses_a - qa),    64'd1000);
    chk("burst.pulse_b", 64'(pulses_b - qb),    64'd1000);
    chk("burst.dport_a", 64'(a_dport), 64'd51000);
    chk("burst.id_a",    64'(a_id),    64'd1000);
    chk("burst.width",   64'(width_err), 64'd0);

    // Reset asserted mid-PAYLOAD, tail becomes its own frame
    v = base; v.dport = 16'd60000; v.id = 16'hBEEF;
    build(v);
    send_beats(0, 40, 1'b0, 8'hFF, 1'b0, 0);
    @(negedge clk156);
    rx_if.tvalid = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk156);
    sys_rst_n = 1'b1;
    send_beats(41, 126, 1'b1, 8'hFF, 1'b0, 0);
    idle(3);
    chk("midrst.tail_pkt_a", 64'(a_pkt), 64'd1);
    chk("midrst.tail_pkt_b", 64'(b_pkt), 64'd1);
    snap();
    v = base; v.dport = 16'd60001; v.id = 16'hCAFE; v.saddr = 32'h0A02_0304;
    build(v);
    send_beats(0, 126, 1'b1, 8'hFF, 1'b0, 0);
    idle(3);
    chk("after.dns_a",   64'(32'(a_dns - da)),  64'd1);
    chk("after.drop_a",  64'(32'(a_drop - ra)), 64'd0);
    chk("after.pulse_a", 64'(pulses_a - qa),    64'd1);
    chk("after.saddr_a", 64'(a_saddr), 64'h0A02_0304);
    chk("after.dport_a", 64'(a_dport), 64'd60001);
    chk("after.id_a",    64'(a_id),    64'hCAFE);
    chk("final.width",   64'(width_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
